// File: rtl/dmem_arb_pkg.sv
// Purpose : shared types and helpers for the data-memory arbiter.
// Latency : n/a (declarations only).
// Backpr. : n/a.
//
// Contents:
//   owner_e       - which requester currently owns the data-memory port
//   starve_cnt_w  - width needed to count 0..STARVE_MAX inclusive
package dmem_arb_pkg;

  typedef enum logic {
    S_CORE = 1'b0,
    S_LOCK = 1'b1
  } owner_e;

  function automatic int starve_cnt_w(input int starve_max);
    return $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Purpose : saturating count of consecutive cycles the loader has been denied.
// Latency : o_at_max reflects the registered count (updates one edge after inc).
// Backpr. : none; clear has priority over increment.
//
// Ports:
//   clk, rst  - clock, async active-high reset (count -> 0)
//   i_inc     - loader requested and was denied this cycle
//   i_clr     - loader granted or not requesting; restart the count
//   o_at_max  - count has reached MAX; loader must win the next contest
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = starve_cnt_w(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares one data-memory port between the core and a loader.
// Latency : grant and mux are combinational; loader read data returns 1 cycle after grant.
// Backpr. : core_stall holds the core; loader holds ldr_req until ldr_gnt.
//
// Ports:
//   clk, rst                         - clock, async active-high reset
//   core_req/we/addr/wdata, core_rdata, core_stall
//                                    - core memory-stage interface
//   ldr_req/we/addr/wdata/lock, ldr_gnt, ldr_rdata, ldr_rvalid
//                                    - loader interface (lock = exclusive burst)
//   mem_re/we/addr/wdata, mem_rdata  - data_mem port (combinational read)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_lock,
  output logic              ldr_gnt,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_rvalid,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e            r_state;
  owner_e            w_state_nxt;
  logic              w_at_max;
  logic              w_ldr_sel;
  logic              w_starve_inc;
  logic              w_starve_clr;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_ldr_rvalid;

  // Loader owns the port during a lock, or when it asks and the core is
  // either idle or has already starved it for STARVE_MAX cycles.
  assign w_ldr_sel  = (r_state == S_LOCK) | (ldr_req & (~core_req | w_at_max));
  assign ldr_gnt    = (r_state == S_LOCK) ? ldr_req : w_ldr_sel;
  assign core_stall = core_req & w_ldr_sel;
  assign core_rdata = mem_rdata;

  always_comb begin
    mem_re    = core_req & ~core_we;
    mem_we    = core_req & core_we;
    mem_addr  = core_addr;
    mem_wdata = core_wdata;
    if (w_ldr_sel) begin
      mem_re    = ldr_req & ~ldr_we;
      mem_we    = ldr_req & ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  // Only a denial while the core owns the port counts toward starvation;
  // inside a lock every loader request is granted, which clears the count.
  assign w_starve_inc = (r_state == S_CORE) & ldr_req & ~ldr_gnt;
  assign w_starve_clr = ldr_gnt | ~ldr_req;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_at_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CORE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Lock is entered only on a granted access and held through idle
  // cycles; there is deliberately no timeout back to the core.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CORE:  if (ldr_gnt & ldr_lock) w_state_nxt = S_LOCK;
      S_LOCK:  if (~ldr_lock)          w_state_nxt = S_CORE;
      default: w_state_nxt = S_CORE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ldr_rvalid <= 1'b0;
      r_ldr_rdata  <= '0;
    end else begin
      r_ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (ldr_gnt & ~ldr_we) begin
        r_ldr_rdata <= mem_rdata;
      end
    end
  end

  assign ldr_rdata  = r_ldr_rdata;
  assign ldr_rvalid = r_ldr_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              core_req, core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata, core_rdata;
  logic              core_stall;
  logic              ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata, ldr_rdata;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt),
    .ldr_rdata(ldr_rdata), .ldr_rvalid(ldr_rvalid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 16-word data memory: combinational read, synchronous write.
  logic [DATA_W-1:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [16];
  bit                m_lock;
  int                m_wait;   // consecutive loader denials while core owns the port
  int                m_age;    // cycles the current loader request has waited (from DUT)
  bit                m_rv;
  logic [DATA_W-1:0] m_rdata;
  bit                e_sel, e_gnt, e_stall, e_re, e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model for the current cycle's inputs.
  task automatic sample();
    @(negedge clk);
    e_sel   = m_lock || (ldr_req && (!core_req || m_wait >= STARVE_MAX));
    e_gnt   = m_lock ? ldr_req : e_sel;
    e_stall = core_req && e_sel;
    if (e_sel) begin
      e_re = ldr_req && !ldr_we; e_we = ldr_req && ldr_we;
      e_addr = ldr_addr; e_wdata = ldr_wdata;
    end else begin
      e_re = core_req && !core_we; e_we = core_req && core_we;
      e_addr = core_addr; e_wdata = core_wdata;
    end
    chk("ldr_gnt", ldr_gnt, e_gnt);
    chk("core_stall", core_stall, e_stall);
    chk("mem_re", mem_re, e_re);
    chk("mem_we", mem_we, e_we);
    if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("ldr_rvalid", ldr_rvalid, m_rv);
    chk("ldr_rdata", ldr_rdata, m_rdata);
    if (core_req && !e_stall && !core_we)
      chk("core_rdata", core_rdata, ref_mem[core_addr[5:2]]);
    chk("mem_excl", mem_re & mem_we, 1'b0);
    chk("gnt_excl", ldr_gnt & core_req & !core_stall, 1'b0);
    if (ldr_req) begin
      if (ldr_gnt) begin
        chk("starve_bound", m_age <= STARVE_MAX, 1'b1);
        m_age = 0;
      end else begin
        m_age++;
      end
    end else begin
      m_age = 0;
    end
  endtask

  // Apply the clock edge to the model, then step just past it.
  task automatic advance();
    @(posedge clk);
    if (e_gnt && !ldr_we) begin
      m_rv = 1'b1; m_rdata = ref_mem[ldr_addr[5:2]];
    end else begin
      m_rv = 1'b0;
    end
    if (e_we) ref_mem[e_addr[5:2]] = e_wdata;
    if (!m_lock && ldr_req && !e_gnt) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : m_wait;
    else m_wait = 0;
    if (!m_lock && e_gnt && ldr_lock) m_lock = 1'b1;
    else if (m_lock && !ldr_lock) m_lock = 1'b0;
    #1;
  endtask

  task automatic set_core(input bit req, input bit we, input logic [31:0] a, input logic [31:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_ldr(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input bit lk);
    ldr_req = req; ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_lock = lk;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin dmem[k] = '0; ref_mem[k] = '0; end
    m_lock = 0; m_wait = 0; m_age = 0; m_rv = 0; m_rdata = '0;
    e_gnt = 0; e_stall = 0;

    // Reset: both request, core must win with a zero starvation count.
    rst = 1'b1;
    set_core(1, 0, 32'h10, 32'h0);
    set_ldr(1, 0, 32'h4, 32'h0, 0);
    #3;
    chk("rst_core_stall", core_stall, 1'b0);
    chk("rst_ldr_gnt", ldr_gnt, 1'b0);
    chk("rst_rvalid", ldr_rvalid, 1'b0);
    chk("rst_rdata", ldr_rdata, 32'h0);
    chk("rst_mem_re", mem_re, 1'b1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    set_core(0, 0, 32'h0, 32'h0);
    set_ldr(0, 0, 32'h0, 32'h0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Core write then read back.
    set_core(1, 1, 32'h10, 32'hDEADBEEF);
    sample();
    chk("core_wr_mem_we", mem_we, 1'b1);
    chk("core_wr_addr", mem_addr, 32'h10);
    chk("core_wr_stall", core_stall, 1'b0);
    advance();
    set_core(1, 0, 32'h10, 32'h0);
    sample();
    chk("core_rd_data", core_rdata, 32'hDEADBEEF);
    advance();

    // Loader read with the core idle: same-cycle grant, data next cycle.
    set_core(0, 0, 32'h0, 32'h0);
    set_ldr(1, 0, 32'h10, 32'h0, 0);
    sample();
    chk("ldr_rd_gnt", ldr_gnt, 1'b1);
    advance();
    set_ldr(0, 0, 32'h0, 32'h0, 0);
    sample();
    chk("ldr_rd_rvalid", ldr_rvalid, 1'b1);
    chk("ldr_rd_data", ldr_rdata, 32'hDEADBEEF);
    advance();

    // Starvation: both held high, loader wins every 9th cycle.
    set_core(1, 0, 32'h10, 32'h0);
    set_ldr(1, 0, 32'h8, 32'h0, 0);
    for (int i = 0; i < 18; i++) begin
      sample();
      chk("starve_gnt", ldr_gnt, (i % 9) == 8);
      chk("starve_stall", core_stall, (i % 9) == 8);
      advance();
    end

    // Lock burst: first beat with core idle, then core stalled throughout.
    set_ldr(0, 0, 32'h0, 32'h0, 0);
    set_core(0, 0, 32'h0, 32'h0);
    sample(); advance();
    for (int b = 0; b < 4; b++) begin
      set_core(b != 0, 0, 32'h10, 32'h0);
      set_ldr(1, 1, 32'(b * 4), 32'hA0 + 32'(b), b != 3);
      sample();
      chk("lock_gnt", ldr_gnt, 1'b1);
      if (b != 0) chk("lock_stall", core_stall, 1'b1);
      advance();
    end
    set_ldr(0, 0, 32'h0, 32'h0, 0);
    set_core(1, 0, 32'hC, 32'h0);
    sample();
    chk("unlock_stall", core_stall, 1'b0);
    chk("unlock_state", dut.r_state, 1'b0);
    chk("unlock_rd", core_rdata, 32'hA3);
    advance();

    // Async reset in the middle of a lock with a loader read in flight.
    set_core(0, 0, 32'h0, 32'h0);
    set_ldr(1, 0, 32'h10, 32'h0, 1);
    sample(); advance();
    set_core(1, 0, 32'h10, 32'h0);
    set_ldr(0, 0, 32'h0, 32'h0, 1);
    sample();
    chk("prerst_stall", core_stall, 1'b1);
    chk("prerst_rvalid", ldr_rvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", core_stall, 1'b0);
    chk("arst_rvalid", ldr_rvalid, 1'b0);
    chk("arst_starve", dut.u_starve.r_cnt, 0);
    chk("arst_gnt", ldr_gnt, 1'b0);
    @(negedge clk);
    ldr_lock = 1'b0;
    rst = 1'b0;
    m_lock = 0; m_wait = 0; m_age = 0; m_rv = 0; m_rdata = '0;
    @(posedge clk); #1;
    e_gnt = 0; e_stall = 0;

    // Randomized traffic; requesters hold their request while waiting.
    for (int i = 0; i < 3000; i++) begin
      if (!(ldr_req && !e_gnt)) begin
        ldr_req   = ($urandom_range(0, 1) == 1);
        ldr_we    = $urandom_range(0, 1) == 1;
        ldr_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        ldr_wdata = $urandom;
        if (m_lock) ldr_lock = ($urandom_range(0, 3) != 0);
        else        ldr_lock = ($urandom_range(0, 15) == 0);
      end
      if (!(core_req && e_stall)) begin
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        core_wdata = $urandom;
      end
      sample();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the single-cycle core and a debug/program-loader requester.
- The core has default priority. A starvation counter guarantees the loader is served within a bounded number of cycles.
- A lock mode lets the loader run back-to-back bursts; during lock the core is stalled.
- Sits between the core's memory-stage signals and data_mem, and drives the core stall used to hold the PC and suppress writeback.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 8, number of consecutive cycles the loader may be denied while the core holds the port; valid range 1..255.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_req  in  1  core memory access this cycle (MemRead | MemWrite).
- core_we  in  1  core write (MemWrite).
- core_addr  in  ADDR_W  core address (ALU result).
- core_wdata  in  DATA_W  core store data (rs2 value).
- core_rdata  out  DATA_W  combinational read data to the core.
- core_stall  out  1  core must hold PC, suppress RegWrite, and keep its request stable.
- ldr_req  in  1  loader access request; held until ldr_gnt.
- ldr_we  in  1  loader write.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_lock  in  1  loader requests exclusive burst ownership.
- ldr_gnt  out  1  loader access performed this cycle.
- ldr_rdata  out  DATA_W  registered loader read data.
- ldr_rvalid  out  1  one-cycle pulse: ldr_rdata valid for the read granted in the previous cycle.
- mem_re  out  1  data_mem MemRead.
- mem_we  out  1  data_mem MemWrite.
- mem_addr  out  ADDR_W  data_mem address.
- mem_wdata  out  DATA_W  data_mem write data.
- mem_rdata  in  DATA_W  data_mem read data (combinational read).

Behaviour:
- Registered state:
  - owner FSM, states S_CORE and S_LOCK.
  - starve_cnt, width clog2(STARVE_MAX+1).
  - ldr_rdata and ldr_rvalid.
- Reset (async, immediate): state S_CORE, starve_cnt 0, ldr_rvalid 0, ldr_rdata 0.
- Reset consequence for combinational outputs: core_stall and ldr_gnt settle to their S_CORE values for the current inputs.
- Grant decision is combinational from state, starve_cnt and requests:
  - ldr_sel = (state==S_LOCK) | (ldr_req & (!core_req | starve_cnt==STARVE_MAX)).
  - In S_LOCK, ldr_gnt = ldr_req.
  - In S_CORE, ldr_gnt = ldr_sel.
  - core_stall = core_req & ldr_sel.
- Memory mux:
  - When ldr_sel: mem_* driven from ldr_*, with mem_re = ldr_req & !ldr_we and mem_we = ldr_req & ldr_we.
  - Otherwise: mem_* driven from core_*, with mem_re = core_req & !core_we and mem_we = core_req & core_we.
  - mem_re and mem_we are never both 1.
- core_rdata = mem_rdata at all times. Its value is meaningful only when core_req & !core_stall.
- Starvation counter:
  - Increments when ldr_req & !ldr_gnt in S_CORE, saturating at STARVE_MAX.
  - Clears on any ldr_gnt and whenever ldr_req = 0.
  - Guarantee: the loader is granted at most STARVE_MAX+1 cycles after it first asserts ldr_req.
- FSM transitions:
  - S_CORE -> S_LOCK when ldr_gnt & ldr_lock.
  - S_LOCK -> S_CORE on the first rising edge where ldr_lock = 0.
  - In S_LOCK, idle cycles (ldr_req = 0) keep ownership and the core stays stalled if it requests. No timeout.
- Loader read return:
  - On an edge where ldr_gnt & !ldr_we: ldr_rdata <= mem_rdata and ldr_rvalid <= 1.
  - Otherwise ldr_rvalid <= 0 and ldr_rdata holds.
  - Latency: read data is available 1 cycle after grant.
- Writes complete at the granting edge (data_mem writes synchronously).
- Simultaneous core and loader request in S_CORE with starve_cnt < STARVE_MAX: core wins, no stall.
- Simultaneous request with starve_cnt == STARVE_MAX: loader wins, core stalled exactly 1 cycle (unless lock is taken).
- Reset during S_LOCK: ownership returns to the core asynchronously. Any in-flight loader read is dropped (ldr_rvalid = 0).
- No X propagation: all outputs are defined while rst is asserted.

Decomposition:
- Package dmem_arb_pkg contains:
  - owner state encoding: S_CORE=1'b0, S_LOCK=1'b1.
  - function returning the starve counter width from STARVE_MAX.
- One natural sub-module, arb_starve_cnt: saturating counter with inc, clr and at_max outputs.
- Muxing and the FSM stay in the top module.

Test Plan:
- Core only: core_req=1, core_we=1, addr 0x10, data 0xDEADBEEF, ldr_req=0 -> mem_we=1, mem_addr 0x10, core_stall=0. A following core read of 0x10 returns 0xDEADBEEF.
- Loader only, core idle: ldr_req=1, ldr_we=0, addr 0x10 -> ldr_gnt=1 the same cycle; next cycle ldr_rvalid=1 and ldr_rdata=0xDEADBEEF.
- Starvation, STARVE_MAX=8: core_req and ldr_req held high continuously -> ldr_gnt=0 for 8 cycles, then ldr_gnt=1 with core_stall=1 on the 9th cycle. starve_cnt returns to 0 and the pattern repeats.
- Lock burst: loader granted with ldr_lock=1, then writes 0x0..0xC in 4 cycles while core_req=1 -> core_stall=1 throughout. ldr_lock drops, and on the next cycle core_stall=0 with state S_CORE.
- Async reset mid-lock: assert rst between clock edges in S_LOCK with core_req=1 -> core_stall falls without waiting for a clock edge, ldr_rvalid=0, starve_cnt=0.
- Exclusivity check under random requests: mem_re & mem_we never both 1, and ldr_gnt & core_req & !core_stall is never true.
